chip_test_sequencer: RTL
========================

Name: chip_test_sequencer

Overview:
Sequences one functional test of a 14-pin DIP logic chip (7400-family) for chip_checker. Fetches test vectors from a synchronous vector ROM, drives the 12 signal pins (pins 1-6, 8-13; 7/14 are power), waits a settle time, samples the pins and compares them against expected values under a mask. Reports pass/fail, the failing vector address and the vector count to the HEX display logic. Sits between the Run/SW front end and the tri-state pin drivers.

Parameters:
NUM_PINS, 12, signal pins under test; bit 0 = Pin1 ... bit 5 = Pin6, bit 6 = Pin8 ... bit 11 = Pin13
ADDR_W, 8, vector ROM address width
SETTLE_CYCLES, 50, cycles from drive to sample (1 us at 50 MHz); elaboration error if < 3
STOP_ON_FAIL, 1, 1 = end the test at the first mismatch; 0 = run all vectors, keep the first failure

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-low reset
Start  in  1  single-cycle start pulse, already debounced and edge-detected upstream
VecBase  in  ADDR_W  first vector address for the selected chip; latched on an accepted Start
RomAddr  out  ADDR_W  vector ROM read address
RomData  in  49  vector word (chip_check_pkg::vec_t), valid one cycle after RomAddr
PinIn  in  NUM_PINS  asynchronous pin readback
PinOut  out  NUM_PINS  drive values
PinOE  out  NUM_PINS  per-pin output enable; 1 = drive
Busy  out  1  test in progress
Done  out  1  level; set at test end, cleared by the next accepted Start
Pass  out  1  valid while Done=1
FailAddr  out  ADDR_W  address of the first failing vector; 0 if none
VecCount  out  ADDR_W  number of vectors compared

Behaviour:
- Reset (async, Reset=0): PinOE=0 immediately (all pins hi-Z), PinOut=0, RomAddr=0, Busy=0, Done=0, Pass=0, FailAddr=0, VecCount=0, state IDLE, synchronizer flops cleared.
- PinIn passes through an internal 2-flop synchronizer. The sample uses the synchronized value.
- Vector word {last, oe, drive, mask, expect}: last[48], oe[47:36], drive[35:24], mask[23:12], expect[11:0].
- States: IDLE, FETCH, APPLY, SETTLE, COMPARE, FINISH.
- IDLE or FINISH with Start=1:
  - latch VecBase into the address counter; RomAddr=VecBase next cycle.
  - Clear Done, Pass, FailAddr, VecCount; set Busy; go to FETCH.
- Start while Busy: ignored.
- FETCH (1 cycle): RomAddr holds the current address; go to APPLY.
- APPLY (1 cycle): register RomData.drive into PinOut and RomData.oe into PinOE; hold expect, mask and last; load the settle counter; go to SETTLE.
- SETTLE: stay for exactly SETTLE_CYCLES cycles; PinOut/PinOE stay stable.
- COMPARE (1 cycle):
  - mismatch = |((sync_pin ^ expect) & mask).
  - VecCount increments.
  - On the first mismatch only: FailAddr = current address and a fail flag is set.
  - Go to FINISH if last=1, if mismatch and STOP_ON_FAIL=1, or if the address is all-ones (wrap guard: the all-ones address is treated as last, with no wrap to 0).
  - Otherwise increment the address and go to FETCH. PinOE/PinOut hold until the next APPLY, so drive values never glitch through 0 between vectors.
- Cycles per vector: 3 + SETTLE_CYCLES. Start-to-first-drive: 2 cycles after the Start cycle.
- FINISH entry (registered):
  - PinOE=0, PinOut=0, Busy=0, Done=1.
  - Pass = ~fail.
  - Stay in FINISH until Start or Reset.
- mask=0 on a vector: that vector always passes; it still counts.
- oe and mask overlapping on a pin is legal (loopback check of the driver).
- Reset mid-test: pins released asynchronously; no partial results are kept.

Decomposition:
- chip_check_pkg: packed struct vec_t (last, oe, drive, mask, expect), enum state_t, NUM_PINS default, pin-bit-to-DIP-pin constants.
- One natural sub-module: pin_sync, a parameterised NUM_PINS-wide 2-flop synchronizer with async active-low clear.
- Sequencer FSM, settle counter and compare logic stay in chip_test_sequencer.

Test Plan:
1. Reset=0 with Start=1 and junk PinIn -> PinOE=0, Busy=0, Done=0, FailAddr=0, VecCount=0. Release reset -> all stay 0, state IDLE.
2. SETTLE_CYCLES=4, VecBase=0x10, 4 NAND vectors (last on 0x13), behavioural 7400 model on the pins -> each vector takes 7 cycles. Done=1, Pass=1, VecCount=4, FailAddr=0, PinOE=0 after finish.
3. Same set with the model's Pin3 stuck-at-1, STOP_ON_FAIL=1 -> stops after 0x11 (first vector where A=B=1 expects 0). Pass=0, FailAddr=0x11, VecCount=2, pins released.
4. STOP_ON_FAIL=0 with the same fault -> VecCount=4, FailAddr=0x11 (first failure kept), Pass=0.
5. Start pulsed mid-SETTLE -> ignored, result unchanged. Start after Done -> Done clears the next cycle and the run repeats with an identical result.
6. ADDR_W=4, VecBase=0xE, no last flags -> vectors 0xE and 0xF run, then FINISH with VecCount=2 and no wrap to 0x0. Separately, Reset=0 during SETTLE -> PinOE=0 in the same timestep, before the next Clk edge.

Source files
------------

// File: rtl/chip_check_pkg.sv
// chip_check_pkg
// Shared types and constants for the 14-pin DIP chip checker.
//   vec_t   : one test vector as stored in the vector ROM
//   state_t : sequencer state encoding
//   *_BIT   : signal-pin bit index for each DIP pin (pins 7 and 14 are power)
package chip_check_pkg;

    localparam int CC_NUM_PINS = 12;
    localparam int CC_VEC_W    = 4 * CC_NUM_PINS + 1;

    // Field order matches the ROM word: last[48], oe[47:36], drive[35:24],
    // mask[23:12], expected[11:0].
    typedef struct packed {
        logic                   last;
        logic [CC_NUM_PINS-1:0] oe;
        logic [CC_NUM_PINS-1:0] drive;
        logic [CC_NUM_PINS-1:0] mask;
        logic [CC_NUM_PINS-1:0] expected;
    } vec_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_COMPARE = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    localparam int PIN1_BIT  = 0;
    localparam int PIN2_BIT  = 1;
    localparam int PIN3_BIT  = 2;
    localparam int PIN4_BIT  = 3;
    localparam int PIN5_BIT  = 4;
    localparam int PIN6_BIT  = 5;
    localparam int PIN8_BIT  = 6;
    localparam int PIN9_BIT  = 7;
    localparam int PIN10_BIT = 8;
    localparam int PIN11_BIT = 9;
    localparam int PIN12_BIT = 10;
    localparam int PIN13_BIT = 11;

endpackage

// File: rtl/pin_sync.sv
// pin_sync
// WIDTH-bit two-flop synchronizer for the asynchronous pin readback.
//   clk   : system clock
//   rst_n : asynchronous active-low clear
//   d     : asynchronous input
//   q     : synchronized output (two clk of latency)
module pin_sync
    import chip_check_pkg::*;
#(
    parameter int WIDTH = CC_NUM_PINS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/chip_test_sequencer.sv
// chip_test_sequencer
// Runs one functional test of a 14-pin DIP logic chip: fetches vectors from
// a synchronous ROM, drives the signal pins, waits SETTLE_CYCLES, samples the
// synchronized readback and compares it against the expected value under mask.
//
//   Clk       : system clock (50 MHz)
//   Reset     : asynchronous active-low reset
//   Start     : one-cycle start pulse, ignored while Busy
//   VecBase   : first vector address, latched on an accepted Start
//   RomAddr   : vector ROM read address
//   RomData   : vector word, valid one cycle after RomAddr
//   PinIn     : asynchronous pin readback
//   PinOut    : pin drive values
//   PinOE     : per-pin output enable (1 = drive)
//   Busy      : test in progress
//   Done      : test finished (level until next accepted Start)
//   Pass      : test result, valid while Done
//   FailAddr  : address of first failing vector, 0 if none
//   VecCount  : number of vectors compared
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for Start after reset, pins released
// FETCH   | RomAddr presented, ROM word arriving next cycle
// APPLY   | ROM word registered onto the pins, settle counter loaded
// SETTLE  | pins held stable for SETTLE_CYCLES cycles
// COMPARE | synchronized pins checked, next address or finish chosen
// FINISH  | pins released, result held until Start or Reset
module chip_test_sequencer
    import chip_check_pkg::*;
#(
    parameter int NUM_PINS      = CC_NUM_PINS,
    parameter int ADDR_W        = 8,
    parameter int SETTLE_CYCLES = 50,
    parameter bit STOP_ON_FAIL  = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_W-1:0]     VecBase,
    output logic [ADDR_W-1:0]     RomAddr,
    input  logic [4*NUM_PINS:0]   RomData,
    input  logic [NUM_PINS-1:0]   PinIn,
    output logic [NUM_PINS-1:0]   PinOut,
    output logic [NUM_PINS-1:0]   PinOE,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Pass,
    output logic [ADDR_W-1:0]     FailAddr,
    output logic [ADDR_W-1:0]     VecCount
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    // The synchronizer needs two cycles after the drive edge before the
    // sampled value reflects the new pin state.
    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("chip_test_sequencer: SETTLE_CYCLES must be >= 3");
        end
    endgenerate

    logic [NUM_PINS-1:0] sync_pin;

    pin_sync #(.WIDTH(NUM_PINS)) u_pin_sync (
        .clk   (Clk),
        .rst_n (Reset),
        .d     (PinIn),
        .q     (sync_pin)
    );

    logic                rom_last;
    logic [NUM_PINS-1:0] rom_oe;
    logic [NUM_PINS-1:0] rom_drive;
    logic [NUM_PINS-1:0] rom_mask;
    logic [NUM_PINS-1:0] rom_expect;

    assign rom_last   = RomData[4*NUM_PINS];
    assign rom_oe     = RomData[4*NUM_PINS-1:3*NUM_PINS];
    assign rom_drive  = RomData[3*NUM_PINS-1:2*NUM_PINS];
    assign rom_mask   = RomData[2*NUM_PINS-1:NUM_PINS];
    assign rom_expect = RomData[NUM_PINS-1:0];

    state_t              state;
    logic [NUM_PINS-1:0] exp_q;
    logic [NUM_PINS-1:0] mask_q;
    logic                last_q;
    logic [CNT_W-1:0]    settle_cnt;
    logic                fail;

    logic mismatch;
    logic fail_nxt;
    logic end_test;

    assign mismatch = |((sync_pin ^ exp_q) & mask_q);
    assign fail_nxt = fail | mismatch;
    // All-ones address ends the run so the counter never wraps to 0.
    assign end_test = last_q | (STOP_ON_FAIL & mismatch) | (&RomAddr);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            RomAddr    <= '0;
            PinOut     <= '0;
            PinOE      <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Pass       <= 1'b0;
            FailAddr   <= '0;
            VecCount   <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
            settle_cnt <= '0;
            fail       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (Start) begin
                        RomAddr  <= VecBase;
                        Done     <= 1'b0;
                        Pass     <= 1'b0;
                        FailAddr <= '0;
                        VecCount <= '0;
                        fail     <= 1'b0;
                        Busy     <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_APPLY;
                end
                ST_APPLY: begin
                    PinOut     <= rom_drive;
                    PinOE      <= rom_oe;
                    exp_q      <= rom_expect;
                    mask_q     <= rom_mask;
                    last_q     <= rom_last;
                    settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_COMPARE: begin
                    VecCount <= VecCount + 1'b1;
                    fail     <= fail_nxt;
                    if (mismatch && !fail) begin
                        FailAddr <= RomAddr;
                    end
                    if (end_test) begin
                        PinOE <= '0;
                        PinOut <= '0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        Pass  <= ~fail_nxt;
                        state <= ST_FINISH;
                    end else begin
                        // Pins keep the previous vector until the next APPLY.
                        RomAddr <= RomAddr + 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
